ps2_key_rx: RTL and testbench

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_key_rx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_key_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard receiver: synchroniser, glitch filter, frame FSM, E0/F0 decode.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses typematic repeats of the held key.
module ps2_key_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_c,
   input  logic        ps2_d,
   output logic [10:0] key_event,
   output logic        key_strobe,
   output logic        frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic          r_c_s1, r_c_s2, r_d_s1, r_d_s2;
   logic          r_c_filt, r_d_filt, r_c_filt_q;
   logic [FW-1:0] r_c_cnt, r_d_cnt;

   state_t        r_state, w_next;
   logic [7:0]    r_shift;
   logic [2:0]    r_bit_cnt;
   logic          r_par;
   logic [TW-1:0] r_to_cnt;
   logic          r_ext_pend, r_brk_pend;
   logic [10:0]   r_key_event;
   logic          r_key_strobe, r_frame_err;

   logic          w_fall, w_stop_ok, w_stop_err, w_timeout, w_repeat;
   logic [10:0]   w_evt;

   // Two-flop synchronisers, then a counter that lets the filtered line
   // follow only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_c_s1     <= 1'b1;
         r_c_s2     <= 1'b1;
         r_d_s1     <= 1'b1;
         r_d_s2     <= 1'b1;
         r_c_filt   <= 1'b1;
         r_d_filt   <= 1'b1;
         r_c_filt_q <= 1'b1;
         r_c_cnt    <= '0;
         r_d_cnt    <= '0;
      end else begin
         r_c_s1     <= ps2_c;
         r_c_s2     <= r_c_s1;
         r_d_s1     <= ps2_d;
         r_d_s2     <= r_d_s1;
         r_c_filt_q <= r_c_filt;
         if (r_c_s2 == r_c_filt) begin
            r_c_cnt <= '0;
         end else if (r_c_cnt == FLT_LAST) begin
            r_c_filt <= r_c_s2;
            r_c_cnt  <= '0;
         end else begin
            r_c_cnt <= r_c_cnt + 1'b1;
         end
         if (r_d_s2 == r_d_filt) begin
            r_d_cnt <= '0;
         end else if (r_d_cnt == FLT_LAST) begin
            r_d_filt <= r_d_s2;
            r_d_cnt  <= '0;
         end else begin
            r_d_cnt <= r_d_cnt + 1'b1;
         end
      end
   end

   assign w_fall = r_c_filt_q & ~r_c_filt;

   always_comb begin
      w_next     = r_state;
      w_stop_ok  = 1'b0;
      w_stop_err = 1'b0;
      w_timeout  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fall && !r_d_filt) w_next = S_DATA;
         end
         S_DATA: begin
            if (w_fall && r_bit_cnt == 3'd7) w_next = S_PARITY;
         end
         S_PARITY: begin
            if (w_fall) w_next = S_STOP;
         end
         S_STOP: begin
            if (w_fall) begin
               w_next = S_IDLE;
               if (r_d_filt && (^{r_shift, r_par})) w_stop_ok = 1'b1;
               else                                 w_stop_err = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
      if (r_state != S_IDLE && !w_fall && r_to_cnt == TO_LAST) begin
         w_timeout = 1'b1;
         w_next    = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_par     <= 1'b0;
         r_to_cnt  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
         else if (!w_timeout)             r_to_cnt <= r_to_cnt + 1'b1;
         if (w_fall) begin
            case (r_state)
               S_IDLE:   r_bit_cnt <= '0;
               S_DATA: begin
                  r_shift   <= {r_d_filt, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
               S_PARITY: r_par <= r_d_filt;
               default:  ;
            endcase
         end
      end
   end

   assign w_evt = {1'b1, r_ext_pend, r_brk_pend, r_shift};

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic       r_held_vld;
   logic [8:0] r_held;
   logic       w_held_match;

   assign w_held_match = r_held_vld && (r_held == {r_ext_pend, r_shift});
   assign w_repeat     = !r_brk_pend && w_held_match;

   // Held key follows makes; a matching break releases it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_held_vld <= 1'b0;
         r_held     <= '0;
      end else if (w_stop_ok && r_shift != 8'hF0 && r_shift != 8'hE0) begin
         if (r_brk_pend) begin
            if (w_held_match) r_held_vld <= 1'b0;
         end else if (!w_held_match) begin
            r_held     <= {r_ext_pend, r_shift};
            r_held_vld <= 1'b1;
         end
      end
   end
`else
   assign w_repeat = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ext_pend   <= 1'b0;
         r_brk_pend   <= 1'b0;
         r_key_event  <= '0;
         r_key_strobe <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_key_strobe <= 1'b0;
         r_frame_err  <= w_stop_err | w_timeout;
         if (w_stop_ok) begin
            if (r_shift == 8'hF0) begin
               r_brk_pend <= 1'b1;
            end else if (r_shift == 8'hE0) begin
               r_ext_pend <= 1'b1;
            end else begin
               r_ext_pend <= 1'b0;
               r_brk_pend <= 1'b0;
               if (!w_repeat) begin
                  r_key_event  <= w_evt;
                  r_key_strobe <= 1'b1;
               end
            end
         end
      end
   end

   assign key_event  = r_key_event;
   assign key_strobe = r_key_strobe;
   assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - self-checking bench for ps2_key_rx: vector table, corner sequences, random frames.
module tb_ps2_key_rx;

   localparam int FL = 4;
   localparam int TO = 300;
   localparam int H  = 12;
`ifdef PS2_TYPEMATIC_FILTER_EN
   localparam int TF = 1;
`else
   localparam int TF = 0;
`endif

   typedef struct {
      logic [7:0]  data;
      bit          bad_par;
      bit          bad_stop;
      logic [10:0] exp_event;
      int          exp_stb;
      int          exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ps2_c;
   logic        ps2_d;
   logic [10:0] key_event;
   logic        key_strobe;
   logic        frame_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t_drop = 0;
   int n_stb = 0, n_err = 0, n_both = 0, last_stb_cyc = -1;

   logic        m_ext, m_brk, m_held_vld;
   logic [8:0]  m_held;
   logic [10:0] m_event;

   vec_t tbl[$];

   ps2_key_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_c      (ps2_c),
      .ps2_d      (ps2_d),
      .key_event  (key_event),
      .key_strobe (key_strobe),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (key_strobe) begin
         n_stb++;
         last_stb_cyc = cyc;
      end
      if (frame_err) n_err++;
      if (key_strobe && frame_err) n_both++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      par = (~^b) ^ bad_par;
      return {~bad_stop, par, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int nb);
      for (int i = 0; i < nb; i++) begin
         ps2_d = bits[i];
         wait_cyc(H);
         ps2_c  = 1'b0;
         t_drop = cyc;
         wait_cyc(H);
         ps2_c = 1'b1;
      end
      ps2_d = 1'b1;
      wait_cyc(2 * H);
   endtask

   task automatic model_reset();
      m_ext = 1'b0; m_brk = 1'b0; m_held_vld = 1'b0; m_held = '0; m_event = '0;
   endtask

   // Reference decode: prefix bytes set flags, other bytes form the event.
   task automatic model_byte(input logic [7:0] b, input bit ok, output int stb, output int err);
      bit rep;
      rep = 0;
      stb = 0;
      err = 0;
      if (!ok) err = 1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else begin
         if (TF == 1) begin
            if (m_brk) begin
               if (m_held_vld && m_held == {m_ext, b}) m_held_vld = 1'b0;
            end else if (m_held_vld && m_held == {m_ext, b}) begin
               rep = 1;
            end else begin
               m_held = {m_ext, b};
               m_held_vld = 1'b1;
            end
         end
         if (!rep) begin
            m_event = {1'b1, m_ext, m_brk, b};
            stb = 1;
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic run_frame(input string nm, input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input logic [10:0] exp_event, input int exp_stb, input int exp_err);
      int s0, e0, ms, me;
      s0 = n_stb;
      e0 = n_err;
      model_byte(b, !(bad_par || bad_stop), ms, me);
      send_bits(frame_bits(b, bad_par, bad_stop), 11);
      check({nm, " strobes"}, n_stb - s0, exp_stb);
      check({nm, " errs"}, n_err - e0, exp_err);
      check({nm, " event"}, {21'd0, key_event}, {21'd0, exp_event});
      if (exp_stb == 1) check({nm, " latency"}, last_stb_cyc - t_drop, FL + 3);
   endtask

   function automatic vec_t mk(input logic [7:0] d, input bit bp, input bit bs,
                               input logic [10:0] ev, input int stb, input int err);
      vec_t v;
      v.data = d; v.bad_par = bp; v.bad_stop = bs; v.exp_event = ev; v.exp_stb = stb; v.exp_err = err;
      return v;
   endfunction

   initial begin
      int s0, e0, stb, err, k;
      logic [7:0] b;
      logic [7:0] codes [5];
      bit bp, bs;

      codes[0] = 8'h1C; codes[1] = 8'h1D; codes[2] = 8'h29; codes[3] = 8'h75; codes[4] = 8'h5A;
      rst = 1'b1; ps2_c = 1'b1; ps2_d = 1'b1;
      model_reset();
      wait_cyc(5);
      check("reset event", {21'd0, key_event}, 32'd0);
      check("reset strobe", {31'd0, key_strobe}, 32'd0);
      check("reset err", {31'd0, frame_err}, 32'd0);
      rst = 1'b0;
      wait_cyc(5);

      tbl.push_back(mk(8'h1D, 0, 0, 11'h41D, 1, 0));
      tbl.push_back(mk(8'hF0, 0, 0, 11'h41D, 0, 0));
      tbl.push_back(mk(8'h1D, 0, 0, 11'h51D, 1, 0));
      tbl.push_back(mk(8'hE0, 0, 0, 11'h51D, 0, 0));
      tbl.push_back(mk(8'hF0, 0, 0, 11'h51D, 0, 0));
      tbl.push_back(mk(8'h75, 0, 0, 11'h775, 1, 0));
      tbl.push_back(mk(8'h29, 0, 0, 11'h429, 1, 0));
      tbl.push_back(mk(8'hF0, 0, 0, 11'h429, 0, 0));
      tbl.push_back(mk(8'h29, 0, 0, 11'h529, 1, 0));
      tbl.push_back(mk(8'h29, 1, 0, 11'h529, 0, 1));
      tbl.push_back(mk(8'h29, 0, 0, 11'h429, 1, 0));
      tbl.push_back(mk(8'hF0, 1, 0, 11'h429, 0, 1));
      tbl.push_back(mk(8'h1D, 0, 0, 11'h41D, 1, 0));
      tbl.push_back(mk(8'h1C, 0, 0, 11'h41C, 1, 0));
      tbl.push_back(mk(8'h1C, 0, 0, 11'h41C, (TF == 1) ? 0 : 1, 0));
      tbl.push_back(mk(8'h1C, 0, 0, 11'h41C, (TF == 1) ? 0 : 1, 0));
      tbl.push_back(mk(8'hF0, 0, 0, 11'h41C, 0, 0));
      tbl.push_back(mk(8'h1C, 0, 0, 11'h51C, 1, 0));
      tbl.push_back(mk(8'h1C, 0, 0, 11'h41C, 1, 0));
      tbl.push_back(mk(8'h33, 0, 1, 11'h41C, 0, 1));
      tbl.push_back(mk(8'hE0, 1, 0, 11'h41C, 0, 1));
      tbl.push_back(mk(8'h5A, 0, 0, 11'h45A, 1, 0));

      for (int i = 0; i < tbl.size(); i++)
         run_frame($sformatf("vec%0d", i), tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop,
                   tbl[i].exp_event, tbl[i].exp_stb, tbl[i].exp_err);

      // Abandoned frames: one timeout error each, pending E0 survives the timeout.
      run_frame("to_e0", 8'hE0, 0, 0, 11'h45A, 0, 0);
      s0 = n_stb; e0 = n_err;
      send_bits(frame_bits(8'h1C, 0, 0), 5);
      wait_cyc(TO + 40);
      check("timeout errs", n_err - e0, 1);
      check("timeout strobes", n_stb - s0, 0);
      run_frame("to_75", 8'h75, 0, 0, 11'h675, 1, 0);
      s0 = n_stb; e0 = n_err;
      send_bits(frame_bits(8'h1C, 0, 0), 5);
      wait_cyc(TO + 40);
      check("timeout2 errs", n_err - e0, 1);
      run_frame("to_1c", 8'h1C, 0, 0, 11'h41C, 1, 0);

      // Reset in the middle of a frame drops it silently.
      e0 = n_err; s0 = n_stb;
      send_bits(frame_bits(8'h2A, 0, 0), 4);
      rst = 1'b1;
      wait_cyc(3);
      check("midrst event", {21'd0, key_event}, 32'd0);
      rst = 1'b0;
      model_reset();
      wait_cyc(5);
      run_frame("midrst_2a", 8'h2A, 0, 0, 11'h42A, 1, 0);
      check("midrst errs", n_err - e0, 0);
      check("midrst strobes", n_stb - s0, 1);

      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 9);
         if (k == 0)      b = 8'hF0;
         else if (k == 1) b = 8'hE0;
         else             b = codes[$urandom_range(0, 4)];
         bp = ($urandom_range(0, 7) == 0);
         bs = !bp && ($urandom_range(0, 11) == 0);
         s0 = n_stb; e0 = n_err;
         model_byte(b, !(bp || bs), stb, err);
         send_bits(frame_bits(b, bp, bs), 11);
         check($sformatf("rnd%0d strobes", i), n_stb - s0, stb);
         check($sformatf("rnd%0d errs", i), n_err - e0, err);
         check($sformatf("rnd%0d event", i), {21'd0, key_event}, {21'd0, m_event});
      end

      check("strobe_err_overlap", n_both, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
